fg_cfg_ctrl: RTL and testbench
==============================

// Module: fg_cfg_ctrl
// PURPOSE
//  Configuration controller for the function generator core. Loads waveform select, frequency tuning word,
//  amplitude and phase offset from the pin bus into shadow registers. Applies them atomically to the
//  datapath on commit, synchronised to the phase-accumulator wrap so the output waveform stays glitch-free.
//  Sits between the top-level pin mux (ui_in/uio_in) and the NCO/waveshaper datapath.
// PARAMETERS
//  SYNC_STAGES  2    flops in each pin synchroniser (>=2)
//  TIMEOUT_W    8    width of commit-timeout counter
//  TIMEOUT_CYC  255  cycles in PEND before forced apply (< 2**TIMEOUT_W)
// PORTS
//  clk        in   1   system clock
//  rst_n      in   1   async active-low reset
//  ena        in   1   design selected; low = controller idle
//  cfg_wr     in   1   async write strobe pin; acts on rising edge
//  cfg_commit in   1   async commit strobe pin; acts on rising edge
//  cfg_addr   in   3   register address
//  cfg_data   in   8   write data
//  acc_wrap   in   1   1-cycle pulse from datapath at phase-accumulator wrap
//  wave_sel   out  2   active waveform: 0 sine, 1 square, 2 triangle, 3 saw
//  out_en     out  1   active output enable
//  ftw        out  16  active frequency tuning word
//  amp        out  8   active amplitude
//  phase      out  8   active phase offset
//  upd        out  1   1-cycle pulse; active registers changed at this edge
//  busy       out  1   commit pending (state PEND)
//  cfg_err    out  1   sticky: write dropped while PEND
//  rd_data    out  8   shadow readback (only with FG_CFG_READBACK_EN)
// BEHAVIOUR
//  Reset: all outputs 0 except amp=8'h80. Shadows take the same values. State IDLE, timeout count 0.
//  Register map: 0 ctrl {5'b0,out_en,wave_sel}; 1 ftw[7:0]; 2 ftw[15:8]; 3 amp; 4 phase.
//   5..7 reserved: writes ignored, no error.
//  Strobes: cfg_wr/cfg_commit pass through SYNC_STAGES flops, then a rising-edge detect.
//   Edge is detected SYNC_STAGES+1 cycles after the pin edge.
//   cfg_addr/cfg_data are sampled raw in the edge-detect cycle; the bus must be stable >= SYNC_STAGES+2 cycles.
//   The shadow register updates at the end of the edge-detect cycle.
//  FSM IDLE:
//   write edge -> shadow update.
//   commit edge -> PEND; timeout count cleared; cfg_err cleared.
//  FSM PEND (busy=1):
//   Exit to IDLE when acc_wrap=1, or active out_en=0 (generator stopped, apply at once), or count==TIMEOUT_CYC.
//   On that exit edge: shadows copy to active outputs and upd=1 for one cycle.
//   Otherwise the count increments.
//   Write edges in PEND are dropped and set cfg_err. Commit edges in PEND are ignored.
//  Simultaneous write+commit edge in IDLE: write lands in shadow first; the commit includes it.
//  ena low: FSM forced to IDLE next cycle, pending commit cancelled (no upd), edges ignored.
//   Active outputs and shadows hold. Synchronisers keep running, so no false edge on re-enable.
//  Reset mid-PEND: everything returns to reset values; no upd.
// CONFIGURATION
//  FG_CFG_READBACK_EN defined:
//   rd_data port present. It is registered: shadow[cfg_addr] sampled every cycle, 1-cycle latency.
//   Reserved addresses read 8'h00.
//  Not defined: rd_data port and its logic absent; no other behaviour changes.
// STRUCTURE
//  Package fg_cfg_pkg: address localparams (ADDR_CTRL..ADDR_PHASE), wave_sel encodings, reset values
//   (AMP_RST=8'h80), FSM state typedef {IDLE,PEND}.
//  Sub-module fg_sync_edge (SYNC_STAGES synchroniser + rising-edge pulse), instantiated for cfg_wr and cfg_commit.
// TESTING
//  1. Reset: rst_n low mid-run -> all outputs 0, amp=8'h80, busy=0, upd=0.
//  2. Write addr1=34, addr2=12, addr0=05, then commit; acc_wrap 10 cycles later.
//     -> ftw=16'h1234, wave_sel=1, out_en=1 on the same edge as the upd pulse. Nothing changes before the wrap.
//  3. out_en=1 active, commit, no acc_wrap -> upd after exactly TIMEOUT_CYC+1 cycles in PEND.
//  4. Write addr3=40 while busy=1 -> cfg_err=1, amp unchanged after apply; next commit clears cfg_err.
//  5. Commit pending, ena low 3 cycles -> busy=0, no upd; re-raise ena -> no spurious write/commit.
//  6. FG_CFG_READBACK_EN: write addr4=A5, hold cfg_addr=4 -> rd_data=A5 one cycle later; addr6 -> 00.

Source files
------------

// File: rtl/fg_cfg_pkg.sv
// fg_cfg_pkg: shared types and constants for the function-generator config controller.
// Holds the register map, waveform codes, reset values, FSM states and shadow/active bundle.
package fg_cfg_pkg;

  localparam logic [2:0] ADDR_CTRL   = 3'd0;
  localparam logic [2:0] ADDR_FTW_LO = 3'd1;
  localparam logic [2:0] ADDR_FTW_HI = 3'd2;
  localparam logic [2:0] ADDR_AMP    = 3'd3;
  localparam logic [2:0] ADDR_PHASE  = 3'd4;

  localparam logic [1:0] WAVE_SINE   = 2'd0;
  localparam logic [1:0] WAVE_SQUARE = 2'd1;
  localparam logic [1:0] WAVE_TRI    = 2'd2;
  localparam logic [1:0] WAVE_SAW    = 2'd3;

  localparam logic [7:0] AMP_RST = 8'h80;

  typedef enum logic {
    IDLE,
    PEND
  } state_t;

  typedef struct packed {
    logic [1:0]  wave_sel;
    logic        out_en;
    logic [15:0] ftw;
    logic [7:0]  amp;
    logic [7:0]  phase;
  } cfg_t;

  localparam cfg_t CFG_RST = '{
    wave_sel: WAVE_SINE,
    out_en:   1'b0,
    ftw:      16'h0000,
    amp:      AMP_RST,
    phase:    8'h00
  };

  function automatic logic addr_valid(input logic [2:0] a);
    return a <= ADDR_PHASE;
  endfunction

  function automatic cfg_t cfg_write(
    input cfg_t       c,
    input logic [2:0] a,
    input logic [7:0] d
  );
    cfg_t r;
    r = c;
    unique case (1'b1)
      (a == ADDR_CTRL): begin
        r.wave_sel = d[1:0];
        r.out_en   = d[2];
      end
      (a == ADDR_FTW_LO): r.ftw[7:0]  = d;
      (a == ADDR_FTW_HI): r.ftw[15:8] = d;
      (a == ADDR_AMP):    r.amp       = d;
      (a == ADDR_PHASE):  r.phase     = d;
      default: ;
    endcase
    return r;
  endfunction

  function automatic logic [7:0] cfg_read(
    input cfg_t       c,
    input logic [2:0] a
  );
    logic [7:0] r;
    r = 8'h00;
    unique case (1'b1)
      (a == ADDR_CTRL):   r = {5'b0, c.out_en, c.wave_sel};
      (a == ADDR_FTW_LO): r = c.ftw[7:0];
      (a == ADDR_FTW_HI): r = c.ftw[15:8];
      (a == ADDR_AMP):    r = c.amp;
      (a == ADDR_PHASE):  r = c.phase;
      default:            r = 8'h00;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/fg_cfg_ctrl_sync_edge.sv
// fg_sync_edge: multi-flop synchroniser for an async pin plus rising-edge pulse.
// Ports: clk, rst_n (async low), i_pin (async), o_rise (1-cycle pulse on synced rise).
module fg_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_pin,
  output logic o_rise
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_pin};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_rise = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule

// File: rtl/fg_cfg_ctrl.sv
// fg_cfg_ctrl: shadow/active config registers for the NCO, committed on accumulator wrap.
// Ports: clk, rst_n, ena, cfg_wr/cfg_commit (async strobes), cfg_addr[3], cfg_data[8],
//  acc_wrap; out wave_sel[2], out_en, ftw[16], amp[8], phase[8], upd, busy, cfg_err,
//  rd_data[8] (only when FG_CFG_READBACK_EN is defined).
module fg_cfg_ctrl
  import fg_cfg_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_W   = 8,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ena,
  input  logic        cfg_wr,
  input  logic        cfg_commit,
  input  logic [2:0]  cfg_addr,
  input  logic [7:0]  cfg_data,
  input  logic        acc_wrap,
  output logic [1:0]  wave_sel,
  output logic        out_en,
  output logic [15:0] ftw,
  output logic [7:0]  amp,
  output logic [7:0]  phase,
  output logic        upd,
  output logic        busy,
`ifdef FG_CFG_READBACK_EN
  output logic [7:0]  rd_data,
`endif
  output logic        cfg_err
);

  logic w_wr_rise;
  logic w_cm_rise;
  logic w_wr;
  logic w_cm;

  state_t r_state;
  state_t w_state_nxt;

  cfg_t r_shadow;
  cfg_t r_act;

  logic [TIMEOUT_W-1:0] r_cnt;
  logic                 r_upd;
  logic                 r_err;

  logic w_shadow_we;
  logic w_apply;
  logic w_cnt_clr;
  logic w_cnt_inc;
  logic w_err_set;
  logic w_err_clr;

  fg_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_wr (
    .clk   (clk),
    .rst_n (rst_n),
    .i_pin (cfg_wr),
    .o_rise(w_wr_rise)
  );

  fg_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_cm (
    .clk   (clk),
    .rst_n (rst_n),
    .i_pin (cfg_commit),
    .o_rise(w_cm_rise)
  );

  // Synchronisers run regardless of ena; only their pulses are gated.
  assign w_wr = w_wr_rise & ena;
  assign w_cm = w_cm_rise & ena;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_shadow_we = 1'b0;
    w_apply     = 1'b0;
    w_cnt_clr   = 1'b0;
    w_cnt_inc   = 1'b0;
    w_err_set   = 1'b0;
    w_err_clr   = 1'b0;
    if (!ena) begin
      w_state_nxt = IDLE;
    end else begin
      unique case (r_state)
        IDLE: begin
          // A same-cycle write lands in the shadow before the commit sees it.
          w_shadow_we = w_wr;
          if (w_cm) begin
            w_state_nxt = PEND;
            w_cnt_clr   = 1'b1;
            w_err_clr   = 1'b1;
          end
        end
        PEND: begin
          w_err_set = w_wr & addr_valid(cfg_addr);
          // Stopped generator has no wrap to wait for, so apply at once.
          if (acc_wrap || !r_act.out_en ||
              r_cnt == TIMEOUT_W'(TIMEOUT_CYC)) begin
            w_apply     = 1'b1;
            w_state_nxt = IDLE;
          end else begin
            w_cnt_inc = 1'b1;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_cnt_clr) begin
      r_cnt <= '0;
    end else if (w_cnt_inc) begin
      r_cnt <= r_cnt + TIMEOUT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow <= CFG_RST;
    end else if (w_shadow_we) begin
      r_shadow <= cfg_write(r_shadow, cfg_addr, cfg_data);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_act <= CFG_RST;
      r_upd <= 1'b0;
    end else begin
      r_upd <= w_apply;
      if (w_apply) begin
        r_act <= r_shadow;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (w_err_clr) begin
      r_err <= 1'b0;
    end else if (w_err_set) begin
      r_err <= 1'b1;
    end
  end

`ifdef FG_CFG_READBACK_EN
  logic [7:0] r_rd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd <= 8'h00;
    end else begin
      r_rd <= cfg_read(r_shadow, cfg_addr);
    end
  end

  assign rd_data = r_rd;
`endif

  assign wave_sel = r_act.wave_sel;
  assign out_en   = r_act.out_en;
  assign ftw      = r_act.ftw;
  assign amp      = r_act.amp;
  assign phase    = r_act.phase;
  assign upd      = r_upd;
  assign busy     = (r_state == PEND);
  assign cfg_err  = r_err;

endmodule

// File: tb/tb_fg_cfg_ctrl.sv
// tb_fg_cfg_ctrl: self-checking bench for fg_cfg_ctrl.
// Expected active configs are queued at commit and checked on every upd pulse.
module tb_fg_cfg_ctrl;

  localparam int SS = 2;
  localparam int TW = 8;
  localparam int TC = 255;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ena;
  logic        cfg_wr;
  logic        cfg_commit;
  logic [2:0]  cfg_addr;
  logic [7:0]  cfg_data;
  logic        acc_wrap;
  logic [1:0]  wave_sel;
  logic        out_en;
  logic [15:0] ftw;
  logic [7:0]  amp;
  logic [7:0]  phase;
  logic        upd;
  logic        busy;
  logic        cfg_err;
`ifdef FG_CFG_READBACK_EN
  logic [7:0]  rd_data;
`endif

  fg_cfg_ctrl #(
    .SYNC_STAGES(SS),
    .TIMEOUT_W  (TW),
    .TIMEOUT_CYC(TC)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .cfg_wr    (cfg_wr),
    .cfg_commit(cfg_commit),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data),
    .acc_wrap  (acc_wrap),
    .wave_sel  (wave_sel),
    .out_en    (out_en),
    .ftw       (ftw),
    .amp       (amp),
    .phase     (phase),
    .upd       (upd),
    .busy      (busy),
`ifdef FG_CFG_READBACK_EN
    .rd_data   (rd_data),
`endif
    .cfg_err   (cfg_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  ws;
    logic        oe;
    logic [15:0] f;
    logic [7:0]  a;
    logic [7:0]  p;
  } exp_t;

  localparam exp_t M_RST = '{ws: 2'd0, oe: 1'b0, f: 16'h0, a: 8'h80, p: 8'h0};

  exp_t m_sh = M_RST;
  exp_t q[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_err = 0;
  int   n_upd = 0;

  always @(negedge clk) begin
    if (rst_n && upd) begin
      n_upd++;
      n_vec++;
      if (q.size() == 0) begin
        n_err++;
        $display("FAIL upd_spurious: got upd=1 at %0t, required no upd", $time);
      end else begin
        mon_e = q.pop_front();
        if ({wave_sel, out_en, ftw, amp, phase} !== mon_e) begin
          n_err++;
          $display("FAIL upd_values: got %h, required %h",
                   {wave_sel, out_en, ftw, amp, phase}, mon_e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic m_write(input logic [2:0] a, input logic [7:0] d);
    case (a)
      3'd0: begin
        m_sh.ws = d[1:0];
        m_sh.oe = d[2];
      end
      3'd1: m_sh.f[7:0]  = d;
      3'd2: m_sh.f[15:8] = d;
      3'd3: m_sh.a       = d;
      3'd4: m_sh.p       = d;
      default: ;
    endcase
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    cfg_addr = a;
    cfg_data = d;
    cfg_wr   = 1'b1;
    repeat (SS + 3) tick();
    cfg_wr = 1'b0;
    repeat (SS + 2) tick();
  endtask

  task automatic cm();
    cfg_commit = 1'b1;
    repeat (SS + 3) tick();
    cfg_commit = 1'b0;
    repeat (2) tick();
  endtask

  task automatic wrap();
    acc_wrap = 1'b1;
    tick();
    acc_wrap = 1'b0;
    tick();
  endtask

  task automatic test_reset_state();
    n_vec++;
    if ({wave_sel, out_en, ftw, amp, phase} !== {M_RST}) begin
      n_err++;
      $display("FAIL reset_active: got %h, required %h",
               {wave_sel, out_en, ftw, amp, phase}, M_RST);
    end
    n_vec++;
    if ({upd, busy, cfg_err} !== 3'b000) begin
      n_err++;
      $display("FAIL reset_flags: got %b, required 000", {upd, busy, cfg_err});
    end
  endtask

  task automatic test_first_apply();
    wr(3'd0, 8'h04);
    m_write(3'd0, 8'h04);
    q.push_back(m_sh);
    cm();
    n_vec++;
    if ({busy, out_en, n_upd} !== {1'b0, 1'b1, 32'd1}) begin
      n_err++;
      $display("FAIL stopped_apply: got busy=%b out_en=%b upds=%0d, required 0 1 1",
               busy, out_en, n_upd);
    end
  endtask

  task automatic test_commit_wrap();
    int u0;
    wr(3'd1, 8'h34);
    m_write(3'd1, 8'h34);
    wr(3'd2, 8'h12);
    m_write(3'd2, 8'h12);
    wr(3'd0, 8'h05);
    m_write(3'd0, 8'h05);
    n_vec++;
    if ({ftw, wave_sel} !== {16'h0000, 2'd0}) begin
      n_err++;
      $display("FAIL shadow_leak: got ftw=%h ws=%0d, required 0000 0", ftw, wave_sel);
    end
    q.push_back(m_sh);
    u0 = n_upd;
    cm();
    repeat (3) tick();
    n_vec++;
    if ({busy, ftw, n_upd} !== {1'b1, 16'h0000, 32'(u0)}) begin
      n_err++;
      $display("FAIL pre_wrap: got busy=%b ftw=%h upds=%0d, required 1 0000 %0d",
               busy, ftw, n_upd, u0);
    end
    wrap();
    n_vec++;
    if ({busy, ftw, wave_sel, out_en, n_upd} !==
        {1'b0, 16'h1234, 2'd1, 1'b1, 32'(u0 + 1)}) begin
      n_err++;
      $display("FAIL post_wrap: got busy=%b ftw=%h ws=%0d oe=%b upds=%0d, required 0 1234 1 1 %0d",
               busy, ftw, wave_sel, out_en, n_upd, u0 + 1);
    end
  endtask

  task automatic test_timeout();
    int  cnt;
    bit  seen;
    bit  done;
    logic up_at;
    cnt   = 0;
    seen  = 0;
    done  = 0;
    up_at = 1'b0;
    q.push_back(m_sh);
    cfg_commit = 1'b1;
    for (int i = 0; i < 600; i++) begin
      tick();
      if (i == SS + 3) cfg_commit = 1'b0;
      if (busy) begin
        cnt++;
        seen = 1;
      end else if (seen) begin
        done  = 1;
        up_at = upd;
        break;
      end
    end
    cfg_commit = 1'b0;
    tick();
    n_vec++;
    if (!done || cnt != TC + 1) begin
      n_err++;
      $display("FAIL timeout_len: got %0d busy cycles (done=%0d), required %0d",
               cnt, done, TC + 1);
    end
    n_vec++;
    if (up_at !== 1'b1) begin
      n_err++;
      $display("FAIL timeout_upd: got upd=%b at busy fall, required 1", up_at);
    end
  endtask

  task automatic test_err();
    q.push_back(m_sh);
    cm();
    wr(3'd3, 8'h40);
    n_vec++;
    if ({busy, cfg_err} !== 2'b11) begin
      n_err++;
      $display("FAIL err_set: got busy=%b cfg_err=%b, required 1 1", busy, cfg_err);
    end
    wrap();
    n_vec++;
    if ({amp, cfg_err} !== {8'h80, 1'b1}) begin
      n_err++;
      $display("FAIL err_drop: got amp=%h cfg_err=%b, required 80 1", amp, cfg_err);
    end
    q.push_back(m_sh);
    cm();
    n_vec++;
    if ({busy, cfg_err} !== 2'b10) begin
      n_err++;
      $display("FAIL err_clear: got busy=%b cfg_err=%b, required 1 0", busy, cfg_err);
    end
    wrap();
  endtask

  task automatic test_ena();
    int u0;
    u0 = n_upd;
    cm();
    ena        = 1'b0;
    cfg_addr   = 3'd3;
    cfg_data   = 8'h11;
    cfg_wr     = 1'b1;
    cfg_commit = 1'b1;
    repeat (3) tick();
    n_vec++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL ena_cancel: got busy=%b, required 0", busy);
    end
    ena = 1'b1;
    repeat (SS + 3) tick();
    n_vec++;
    if ({busy, n_upd} !== {1'b0, 32'(u0)}) begin
      n_err++;
      $display("FAIL ena_spurious: got busy=%b upds=%0d, required 0 %0d", busy, n_upd, u0);
    end
    cfg_wr     = 1'b0;
    cfg_commit = 1'b0;
    repeat (3) tick();
    q.push_back(m_sh);
    cm();
    wrap();
    n_vec++;
    if (amp !== m_sh.a) begin
      n_err++;
      $display("FAIL ena_nowrite: got amp=%h, required %h", amp, m_sh.a);
    end
  endtask

  task automatic test_back_to_back();
    cfg_addr   = 3'd2;
    cfg_data   = 8'hAB;
    cfg_wr     = 1'b1;
    cfg_commit = 1'b1;
    repeat (SS + 3) tick();
    cfg_wr     = 1'b0;
    cfg_commit = 1'b0;
    repeat (2) tick();
    m_write(3'd2, 8'hAB);
    q.push_back(m_sh);
    n_vec++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_pend: got busy=%b, required 1", busy);
    end
    wrap();
    n_vec++;
    if (ftw !== 16'hAB34) begin
      n_err++;
      $display("FAIL b2b_ftw: got %h, required ab34", ftw);
    end
  endtask

`ifdef FG_CFG_READBACK_EN
  task automatic test_readback();
    wr(3'd4, 8'hA5);
    m_write(3'd4, 8'hA5);
    cfg_addr = 3'd4;
    tick();
    n_vec++;
    if (rd_data !== 8'hA5) begin
      n_err++;
      $display("FAIL rd_phase: got %h, required a5", rd_data);
    end
    cfg_addr = 3'd6;
    tick();
    n_vec++;
    if (rd_data !== 8'h00) begin
      n_err++;
      $display("FAIL rd_reserved: got %h, required 00", rd_data);
    end
    cfg_addr = 3'd1;
    tick();
    n_vec++;
    if (rd_data !== m_sh.f[7:0]) begin
      n_err++;
      $display("FAIL rd_ftw_lo: got %h, required %h", rd_data, m_sh.f[7:0]);
    end
  endtask
`endif

  task automatic test_reset_mid();
    int u0;
    u0 = n_upd;
    cfg_commit = 1'b1;
    repeat (SS + 3) tick();
    cfg_commit = 1'b0;
    tick();
    n_vec++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL rst_pre: got busy=%b, required 1", busy);
    end
    rst_n = 1'b0;
    #2;
    n_vec++;
    if ({wave_sel, out_en, ftw, amp, phase, upd, busy, cfg_err} !==
        {M_RST, 3'b000}) begin
      n_err++;
      $display("FAIL rst_mid: got %h, required %h",
               {wave_sel, out_en, ftw, amp, phase, upd, busy, cfg_err}, {M_RST, 3'b000});
    end
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (5) tick();
    n_vec++;
    if ({busy, n_upd} !== {1'b0, 32'(u0)}) begin
      n_err++;
      $display("FAIL rst_noupd: got busy=%b upds=%0d, required 0 %0d", busy, n_upd, u0);
    end
    m_sh = M_RST;
    q.delete();
  endtask

  task automatic test_stop_apply();
    wr(3'd3, 8'h33);
    m_write(3'd3, 8'h33);
    q.push_back(m_sh);
    cm();
    n_vec++;
    if ({amp, busy} !== {8'h33, 1'b0}) begin
      n_err++;
      $display("FAIL stop_apply: got amp=%h busy=%b, required 33 0", amp, busy);
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    ena        = 1'b1;
    cfg_wr     = 1'b0;
    cfg_commit = 1'b0;
    cfg_addr   = 3'd0;
    cfg_data   = 8'h00;
    acc_wrap   = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    test_reset_state();
    test_first_apply();
    test_commit_wrap();
    test_timeout();
    test_err();
    test_ena();
    test_back_to_back();
`ifdef FG_CFG_READBACK_EN
    test_readback();
`endif
    test_reset_mid();
    test_stop_apply();
    repeat (3) tick();
    n_vec++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL missing_upd: got %0d unapplied commits, required 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
